// File: rtl/regfile_pkg.sv
// Shared register-file types, defaults and the address-width helper.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]          reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for load-use hazards; issue sets, port-1 write clears.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int AW     = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD-1:0]   rbusy,
  output logic                busy_any
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a new producer replaces the old one.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (we1 && waddr1 != '0)
        busy_d[waddr1] = 1'b0;
      if (issue_valid && issue_rd != '0)
        busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rb
    assign rbusy[i] = busy_q[raddr[i*AW +: AW]];
  end

  assign busy_any = |busy_q[NREGS-1:1];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD reads, two writes, busy scoreboard.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NUM_RD = 2,
  localparam int AW     = addr_w(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata,
  output logic [NUM_RD-1:0]      rbusy,
  input  logic                   we0,
  input  logic [AW-1:0]          waddr0,
  input  logic [XLEN-1:0]        wdata0,
  input  logic                   we1,
  input  logic [AW-1:0]          waddr1,
  input  logic [XLEN-1:0]        wdata1,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic                   busy_any
);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [NUM_RD-1:0] sb_rbusy;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .AW     (AW)
  ) u_sb (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we1         (we1),
    .waddr1      (waddr1),
    .raddr       (raddr),
    .rbusy       (sb_rbusy),
    .busy_any    (busy_any)
  );

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (run) begin
      if (we0 && waddr0 != '0)
        regs_d[waddr0] = wdata0;
      if (we1 && waddr1 != '0)
        regs_d[waddr1] = wdata1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++)
        regs_q[k] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = raddr[i*AW +: AW];

    always_comb begin
      d = regs_q[a];
      b = sb_rbusy[i];
`ifdef REGFILE_BYPASS_EN
      if (run && a != '0) begin
        if (we1 && waddr1 == a) begin
          d = wdata1;
          b = issue_valid && issue_rd == a;
        end else if (we0 && waddr0 == a) begin
          d = wdata0;
        end
      end
`endif
    end

    assign rdata[i*XLEN +: XLEN] = d;
    assign rbusy[i]              = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        we0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        busy_any;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .we0         (we0),
    .waddr0      (waddr0),
    .wdata0      (wdata0),
    .we1         (we1),
    .waddr1      (waddr1),
    .wdata1      (wdata1),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_any    (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we0 = 0; waddr0 = 0; wdata0 = 0;
    we1 = 0; waddr1 = 0; wdata1 = 0;
    issue_valid = 0; issue_rd = 0;
    run = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    raddr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rdata !== 64'h0 || rbusy !== 2'b00 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: rdata=%h rbusy=%b any=%b want 0", rdata, rbusy, busy_any);
    end
    #11 reset_n = 1;
    tick();
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    issue_valid = 1; issue_rd = 6;
    tick();
    idle();
    #1;
    checks++;
    if (rdata[31:0] !== 32'hDEADBEEF || busy_any !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: r5=%h any=%b want deadbeef 1", rdata[31:0], busy_any);
    end
    #1 reset_n = 0;
    #1;
    checks++;
    if (rdata[31:0] !== 32'h0 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: r5=%h any=%b want 0 0", rdata[31:0], busy_any);
    end
    #1 reset_n = 1;
    tick();
    checks++;
    if (rdata[31:0] !== 32'h0 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_post: r5=%h any=%b want 0 0", rdata[31:0], busy_any);
    end
  endtask

  task automatic test_r0();
    idle();
    raddr = {5'd0, 5'd0};
    we0 = 1; waddr0 = 0; wdata0 = 32'h1234;
    we1 = 1; waddr1 = 0; wdata1 = 32'h5678;
    issue_valid = 1; issue_rd = 0;
    #1;
    checks++;
    if (rdata !== 64'h0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL r0_same: rdata=%h rbusy=%b want 0", rdata, rbusy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdata !== 64'h0 || rbusy !== 2'b00 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL r0_next: rdata=%h rbusy=%b any=%b want 0", rdata, rbusy, busy_any);
    end
  endtask

  task automatic test_collision();
    idle();
    we0 = 1; waddr0 = 7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22;
    tick();
    idle();
    raddr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rdata !== {32'h22, 32'h22}) begin
      errors++;
      $display("FAIL collision: rdata=%h want 22 on both ports", rdata);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    issue_valid = 1; issue_rd = 9;
    tick();
    idle();
    raddr = {5'd7, 5'd9};
    #1;
    checks++;
    if (rbusy !== 2'b01 || busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_set: rbusy=%b any=%b want 01 1", rbusy, busy_any);
    end
    we0 = 1; waddr0 = 9; wdata0 = 32'h33;
    tick();
    idle();
    #1;
    checks++;
    if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'h33) begin
      errors++;
      $display("FAIL sb_we0: rbusy=%b r9=%h want 1 33", rbusy[0], rdata[31:0]);
    end
    we1 = 1; waddr1 = 9; wdata1 = 32'h55;
    #1;
    checks++;
    if (rbusy[0] !== !BYP || rdata[31:0] !== (BYP ? 32'h55 : 32'h33)) begin
      errors++;
      $display("FAIL sb_clr_same: rbusy=%b r9=%h want %b %h",
               rbusy[0], rdata[31:0], !BYP, BYP ? 32'h55 : 32'h33);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h55 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL sb_clr: rbusy=%b r9=%h any=%b want 0 55 0", rbusy[0], rdata[31:0], busy_any);
    end
    we1 = 1; waddr1 = 9; wdata1 = 32'h66;
    issue_valid = 1; issue_rd = 9;
    tick();
    idle();
    #1;
    checks++;
    if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'h66 || busy_any !== 1'b1) begin
      errors++;
      $display("FAIL sb_setwins: rbusy=%b r9=%h any=%b want 1 66 1", rbusy[0], rdata[31:0], busy_any);
    end
    we1 = 1; waddr1 = 9; wdata1 = 32'h66;
    tick();
    idle();
  endtask

  task automatic test_run();
    idle();
    we0 = 1; waddr0 = 3; wdata0 = 32'h33;
    tick();
    idle();
    raddr = {5'd0, 5'd3};
    run = 0;
    we0 = 1; waddr0 = 3; wdata0 = 32'hAA;
    we1 = 1; waddr1 = 3; wdata1 = 32'hBB;
    issue_valid = 1; issue_rd = 3;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rdata[31:0] !== 32'h33 || rbusy[0] !== 1'b0 || busy_any !== 1'b0) begin
        errors++;
        $display("FAIL run0_c%0d: r3=%h rbusy=%b any=%b want 33 0 0",
                 c, rdata[31:0], rbusy[0], busy_any);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    we0 = 1; waddr0 = 4; wdata0 = 32'h44;
    issue_valid = 1; issue_rd = 4;
    tick();
    idle();
    raddr = {5'd4, 5'd4};
    we1 = 1; waddr1 = 4; wdata1 = 32'h77;
    #1;
    checks++;
    if (rdata[31:0] !== (BYP ? 32'h77 : 32'h44) || rbusy[0] !== !BYP) begin
      errors++;
      $display("FAIL byp_we1: r4=%h rbusy=%b want %h %b",
               rdata[31:0], rbusy[0], BYP ? 32'h77 : 32'h44, !BYP);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdata[63:32] !== 32'h77 || rbusy[1] !== 1'b0) begin
      errors++;
      $display("FAIL byp_next: r4=%h rbusy=%b want 77 0", rdata[63:32], rbusy[1]);
    end
    we0 = 1; waddr0 = 4; wdata0 = 32'h88;
    #1;
    checks++;
    if (rdata[63:32] !== (BYP ? 32'h88 : 32'h77)) begin
      errors++;
      $display("FAIL byp_we0: r4=%h want %h", rdata[63:32], BYP ? 32'h88 : 32'h77);
    end
    tick();
    idle();
    we1 = 1; waddr1 = 4; wdata1 = 32'h99;
    issue_valid = 1; issue_rd = 4;
    #1;
    checks++;
    if (rbusy[1] !== BYP || rdata[63:32] !== (BYP ? 32'h99 : 32'h88)) begin
      errors++;
      $display("FAIL byp_issue: rbusy=%b r4=%h want %b %h",
               rbusy[1], rdata[63:32], BYP, BYP ? 32'h99 : 32'h88);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rbusy !== 2'b11 || rdata !== {32'h99, 32'h99}) begin
      errors++;
      $display("FAIL byp_issue_next: rbusy=%b rdata=%h want 11 99/99", rbusy, rdata);
    end
  endtask

  initial begin
    reset_n = 0;
    raddr = '0;
    idle();
    test_reset();
    test_r0();
    test_collision();
    test_scoreboard();
    test_run();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
